// File: rtl/map_color_pkg.sv
// Shared types and constants for the Oz map coloring search.
// Regions are assigned in the order EC, GC, WC, QC, MC (levels 0..4).
package map_color_pkg;

    localparam int r_ec = 0;
    localparam int r_gc = 1;
    localparam int r_wc = 2;
    localparam int r_qc = 3;
    localparam int r_mc = 4;

    typedef logic [1:0] color_t;

    typedef enum logic [1:0] {
        st_idle,
        st_search,
        st_emit,
        st_done
    } state_t;

    // Row = region, bit = lower-level neighbor that it must differ from.
    localparam logic [4:0][4:0] adj = {
        5'b01011,
        5'b00101,
        5'b00011,
        5'b00001,
        5'b00000
    };

endpackage

// File: rtl/map_color_conflict.sv
// Combinational check: does the color at the current level clash
// with any already assigned lower-level neighbor?
module map_color_conflict
    import map_color_pkg::*;
(
    input  logic   [2:0]       lvl,
    input  color_t [4:0]       cols,
    output logic               conflict
);

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (lvl <= 3'd4 && j < int'(lvl)
                && adj[lvl][j]
                && cols[j[2:0]] == cols[lvl])
                conflict = 1'b1;
        end
    end

endmodule

// File: rtl/map_color_solver.sv
// Depth-first backtracking enumerator of all proper colorings of the
// five-region Oz map, streamed out in lexicographic order.
module map_color_solver
    import map_color_pkg::*;
#(
    parameter int NUM_COLORS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [1:0]       GC,
    output logic [1:0]       WC,
    output logic [1:0]       QC,
    output logic [1:0]       MC,
    output logic [1:0]       EC,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sol_count
);

    localparam color_t maxc = color_t'(NUM_COLORS - 1);
    localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);

    state_t         state;
    logic   [2:0]   lvl;
    color_t [4:0]   cols;
    logic           bump;
    logic           conflict;
    logic           blocked;

    map_color_conflict u_conflict (
        .lvl      (lvl),
        .cols     (cols),
        .conflict (conflict)
    );

    // After a backtrack the revisited level must advance even though
    // its color was previously consistent.
    assign blocked = conflict | bump;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= st_idle;
            lvl       <= 3'd0;
            cols      <= '0;
            bump      <= 1'b0;
            sol_count <= '0;
        end else begin
            unique case (state)
                st_idle, st_done: begin
                    if (start) begin
                        cols      <= '0;
                        lvl       <= 3'd0;
                        bump      <= 1'b0;
                        sol_count <= '0;
                        state     <= st_search;
                    end
                end
                st_search: begin
                    bump <= 1'b0;
                    if (!blocked) begin
                        if (lvl == 3'd4) begin
                            state <= st_emit;
                        end else begin
                            lvl               <= lvl + 3'd1;
                            cols[lvl + 3'd1]  <= '0;
                        end
                    end else if (cols[lvl] != maxc) begin
                        cols[lvl] <= cols[lvl] + 2'd1;
                    end else if (lvl == 3'd0) begin
                        state <= st_done;
                    end else begin
                        lvl  <= lvl - 3'd1;
                        bump <= 1'b1;
                    end
                end
                st_emit: begin
                    if (sol_ready) begin
                        if (sol_count != '1)
                            sol_count <= sol_count + cnt_one;
                        if (cols[r_mc] != maxc) begin
                            cols[r_mc] <= cols[r_mc] + 2'd1;
                        end else begin
                            lvl  <= lvl - 3'd1;
                            bump <= 1'b1;
                        end
                        state <= st_search;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign sol_valid = (state == st_emit);
    assign busy      = (state == st_search) || (state == st_emit);
    assign done      = (state == st_done);

    assign EC = cols[r_ec];
    assign GC = cols[r_gc];
    assign WC = cols[r_wc];
    assign QC = cols[r_qc];
    assign MC = cols[r_mc];

endmodule

// File: tb/tb_map_color_solver.sv
// Self-checking bench: three solver instances (4, 3 and 2 colors)
// compared against a brute-force enumeration of valid Oz colorings.
module tb_map_color_solver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start3, start2;
    logic       r4, r3, r2;
    int         rmode;

    logic       v4, b4, d4;
    logic [1:0] gc4, wc4, qc4, mc4, ec4;
    logic [7:0] cnt4;
    logic       v3, b3, d3;
    logic [1:0] gc3, wc3, qc3, mc3, ec3;
    logic [7:0] cnt3;
    logic       v2, b2, d2;
    logic [1:0] gc2, wc2, qc2, mc2, ec2;
    logic [7:0] cnt2;

    logic [9:0] exp4[$];
    logic [9:0] exp3[$];
    logic [9:0] exp2[$];
    logic [9:0] tmpq[$];
    logic [9:0] pin;
    int         idx4, idx3;
    int         nchk, nerr;

    always #5 clk = ~clk;

    map_color_solver #(.NUM_COLORS(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .sol_valid(v4), .sol_ready(r4),
        .GC(gc4), .WC(wc4), .QC(qc4), .MC(mc4), .EC(ec4),
        .busy(b4), .done(d4), .sol_count(cnt4)
    );

    map_color_solver #(.NUM_COLORS(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .sol_valid(v3), .sol_ready(r3),
        .GC(gc3), .WC(wc3), .QC(qc3), .MC(mc3), .EC(ec3),
        .busy(b3), .done(d3), .sol_count(cnt3)
    );

    map_color_solver #(.NUM_COLORS(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .sol_valid(v2), .sol_ready(r2),
        .GC(gc2), .WC(wc2), .QC(qc2), .MC(mc2), .EC(ec2),
        .busy(b2), .done(d2), .sol_count(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Ring G-W-Q-M-G, with Emerald City touching every ring region.
    function automatic bit legal(int e, int g, int w, int q, int m);
        if (g == w || w == q || q == m || m == g) return 0;
        if (e == g || e == w || e == q || e == m) return 0;
        return 1;
    endfunction

    function automatic void gen(int n);
        tmpq.delete();
        for (int e = 0; e < n; e++)
            for (int g = 0; g < n; g++)
                for (int w = 0; w < n; w++)
                    for (int q = 0; q < n; q++)
                        for (int m = 0; m < n; m++)
                            if (legal(e, g, w, q, m))
                                tmpq.push_back({2'(e), 2'(g),
                                    2'(w), 2'(q), 2'(m)});
    endfunction

    always @(posedge clk) begin
        #2;
        case (rmode)
            0: r4 = 1'b0;
            1: r4 = 1'b1;
            2: r4 = ($urandom_range(0, 99) < 30);
            default: r4 = (cnt4 != 8'd9);
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            idx4 = 0;
        end else begin
            if (d4) chk("valid_in_done4", {31'd0, v4}, 0);
            if (v4) begin
                if (idx4 < exp4.size())
                    chk("tuple4", {22'd0, ec4, gc4, wc4, qc4, mc4},
                        {22'd0, exp4[idx4]});
                else
                    chk("extra_tuple4", {31'd0, v4}, 0);
                if (r4) idx4++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            idx3 = 0;
        end else if (v3) begin
            if (idx3 < exp3.size())
                chk("tuple3", {22'd0, ec3, gc3, wc3, qc3, mc3},
                    {22'd0, exp3[idx3]});
            else
                chk("extra_tuple3", {31'd0, v3}, 0);
            if (r3) idx3++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) chk("valid2_never", {31'd0, v2}, 0);
    end

    task automatic pulse(input bit s4, input bit s3, input bit s2);
        @(posedge clk);
        #2;
        start4 = s4;
        start3 = s3;
        start2 = s2;
        @(posedge clk);
        #2;
        start4 = 1'b0;
        start3 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done4();
        int n;
        n = 0;
        while (!d4 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("done4_reached", {31'd0, d4}, 1);
    endtask

    task automatic wait_stall9();
        int n;
        n = 0;
        while (!(v4 && cnt4 == 8'd9) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_emit10", {31'd0, v4}, 1);
    endtask

    initial begin
        int n, lat;
        nchk = 0;
        nerr = 0;
        idx4 = 0;
        idx3 = 0;
        rst_n = 1'b0;
        start4 = 1'b0;
        start3 = 1'b0;
        start2 = 1'b0;
        r3 = 1'b1;
        r2 = 1'b1;
        r4 = 1'b1;
        rmode = 1;

        gen(4);
        exp4 = tmpq;
        gen(3);
        exp3 = tmpq;
        gen(2);
        exp2 = tmpq;
        chk("model_size4", exp4.size(), 72);
        chk("model_size3", exp3.size(), 6);
        chk("model_size2", exp2.size(), 0);
        pin = exp4[0];
        chk("model_first4", {22'd0, pin}, {22'd0, 10'b00_01_10_01_10});
        pin = exp4[71];
        chk("model_last4", {22'd0, pin}, {22'd0, 10'b11_10_01_10_01});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, v4}, 0);
        chk("rst_busy", {31'd0, b4}, 0);
        chk("rst_done", {31'd0, d4}, 0);
        chk("rst_count", {24'd0, cnt4}, 0);
        chk("rst_colors", {22'd0, ec4, gc4, wc4, qc4, mc4}, 0);
        chk("rst_done3", {31'd0, d3}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full runs with ready held high on all three instances.
        idx4 = 0;
        idx3 = 0;
        pulse(1, 1, 1);
        lat = 0;
        while (!v4 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("first_latency_ge5", {31'd0, lat >= 5}, 1);
        wait_done4();
        chk("count4", {24'd0, cnt4}, 72);
        chk("accepted4", idx4, 72);
        chk("busy4_done", {31'd0, b4}, 0);
        n = 0;
        while (!(d3 && d2) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done3", {31'd0, d3}, 1);
        chk("count3", {24'd0, cnt3}, 6);
        chk("accepted3", idx3, 6);
        chk("done2", {31'd0, d2}, 1);
        chk("count2", {24'd0, cnt2}, 0);

        // Restart from DONE under random back-pressure.
        rmode = 2;
        idx4 = 0;
        pulse(1, 0, 0);
        @(negedge clk);
        chk("restart_count", {24'd0, cnt4}, 0);
        chk("restart_done", {31'd0, d4}, 0);
        chk("restart_busy", {31'd0, b4}, 1);
        wait_done4();
        chk("count4_bp", {24'd0, cnt4}, 72);
        chk("accepted4_bp", idx4, 72);
        rmode = 1;

        // Reset while the tenth solution is stalled on the stream.
        rmode = 3;
        idx4 = 0;
        pulse(1, 0, 0);
        wait_stall9();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'd0, v4}, 0);
        chk("midrst_count", {24'd0, cnt4}, 0);
        chk("midrst_busy", {31'd0, b4}, 0);
        chk("midrst_done", {31'd0, d4}, 0);
        rmode = 1;
        idx4 = 0;
        pulse(1, 0, 0);
        wait_done4();
        chk("count4_after_rst", {24'd0, cnt4}, 72);
        chk("accepted4_after_rst", idx4, 72);

        // start in SEARCH and in EMIT must be ignored.
        rmode = 3;
        idx4 = 0;
        pulse(1, 0, 0);
        repeat (3) @(negedge clk);
        pulse(1, 0, 0);
        @(negedge clk);
        chk("ign_search_busy", {31'd0, b4}, 1);
        wait_stall9();
        pulse(1, 0, 0);
        @(negedge clk);
        chk("ign_emit_count", {24'd0, cnt4}, 9);
        chk("ign_emit_valid", {31'd0, v4}, 1);
        rmode = 1;
        wait_done4();
        chk("count4_ignored", {24'd0, cnt4}, 72);
        chk("accepted4_ignored", idx4, 72);

        idx4 = 0;
        pulse(1, 0, 0);
        @(negedge clk);
        chk("done_restart_count", {24'd0, cnt4}, 0);
        chk("done_restart_busy", {31'd0, b4}, 1);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule

// File: doc/map_color_solver.md
Name: map_color_solver

Overview:
- Sequential generator for the Land of Oz five-region map: Gillikin, Winkie, Quadling and Munchkin form a ring, and Emerald City is adjacent to all four.
- On start, a depth-first backtracking search enumerates every proper coloring with NUM_COLORS colors, in lexicographic order.
- Each solution is emitted on a valid/ready stream. A done flag and a total solution count follow the last one.
- It is the producer side of the coloring-validity check: every emitted tuple must pass that check.

Parameters:
- NUM_COLORS, 4, number of usable colors, legal range 1..4, encoded 0..NUM_COLORS-1 on 2-bit ports.
- CNT_W, 8, width of sol_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a search from IDLE or DONE.
- sol_valid  output  1  a coloring is presented on GC/WC/QC/MC/EC.
- sol_ready  input  1  consumer accepts the coloring when sol_valid && sol_ready.
- GC  output  2  Gillikin Country color.
- WC  output  2  Winkie Country color.
- QC  output  2  Quadling Country color.
- MC  output  2  Munchkin Country color.
- EC  output  2  Emerald City color.
- busy  output  1  high in SEARCH or EMIT.
- done  output  1  high in DONE; search space exhausted.
- sol_count  output  CNT_W  number of solutions accepted in the current or last run.

Behaviour:
- Reset, sampled on clk with rst_n low: state IDLE. sol_valid, busy and done are 0; sol_count is 0; all color registers are 0. Reset mid-search or mid-EMIT aborts immediately with no partial output.
- Assignment order is fixed as levels 0..4 = EC, GC, WC, QC, MC. Level pointer lvl is 3 bits; each level holds a 2-bit color register.
- Neighbors checked at each level, against lower levels only:
  - GC: EC.
  - WC: EC, GC.
  - QC: EC, WC.
  - MC: EC, QC, GC.
- FSM states: IDLE, SEARCH, EMIT, DONE.
- IDLE/DONE + start: clear all colors, set lvl=0, clear sol_count, clear done, go to SEARCH. start in SEARCH or EMIT is ignored.
- SEARCH performs exactly one action per cycle:
  - (a) Current color conflicts with no assigned neighbor and lvl<4: lvl++, and the new level's color starts at 0.
  - (b) Same as (a) but lvl==4: go to EMIT.
  - (c) Conflict and color<NUM_COLORS-1: color++.
  - (d) Conflict and color==NUM_COLORS-1, i.e. level exhausted: if lvl==0 go to DONE; otherwise lvl--, then increment that lower level's color or exhaust it in turn on later cycles.
- Backtrack rule: exhausting a level never skips more than one level per cycle.
- EMIT:
  - sol_valid=1. Outputs are driven from the level registers and held stable until sol_valid && sol_ready.
  - On the handshake: sol_count++, saturating at all-ones. Then treat lvl 4 as exhausted-or-increment per (c)/(d) and return to SEARCH on the next cycle.
  - sol_valid drops the cycle after acceptance.
- First emission occurs no earlier than 5 SEARCH cycles after start.
- DONE: done=1, busy=0, sol_valid=0, sol_count stable. Colors hold the last tried values, which are don't-care.
- NUM_COLORS=1 or 2: no solutions. DONE is reached with sol_count=0 and sol_valid never asserts.
- Back-pressure: sol_ready low for any duration stalls the search with no state change and no lost or duplicated solution.
- Expected solution counts: 72 for 4 colors, 6 for 3 colors.

Decomposition:
- Package map_color_pkg holds:
  - region index constants (EC=0, GC=1, WC=2, QC=3, MC=4);
  - the 2-bit color typedef;
  - the FSM state enum;
  - the lower-neighbor adjacency constant, a 5x5 bit matrix.
- Sub-module map_color_conflict is purely combinational. It takes lvl and the five color registers and returns conflict=1 when the current level's color equals any assigned lower neighbor's color, using the adjacency constant.

Test Plan:
- NUM_COLORS=4, sol_ready tied 1, start pulse:
  - first emitted tuple is EC=0, GC=1, WC=2, QC=1, MC=2;
  - last is EC=3, GC=2, WC=1, QC=2, MC=1;
  - done rises with sol_count=72.
- NUM_COLORS=3, sol_ready=1 → exactly 6 tuples, all pairwise-distinct, then done with sol_count=6.
- NUM_COLORS=2 → done with sol_count=0; sol_valid never high.
- NUM_COLORS=4, sol_ready random 30% duty:
  - outputs are stable while stalled;
  - the 72 tuples are identical and in the same order as the ready=1 run;
  - every tuple passes an independent adjacency-validity model.
- rst_n low for 1 cycle during the 10th EMIT → next cycle IDLE, sol_valid=0, sol_count=0. A new start reproduces the full 72-tuple run.
- start pulsed during SEARCH and during EMIT → ignored, with no count reset. start in DONE restarts the search and sol_count clears to 0.
